sm_mdu: RTL and testbench
=========================

// Module: sm_mdu
// PURPOSE
//  Iterative multiply/divide unit with architectural HI/LO registers for the schoolMIPS core.
//  Parametrised successor of the single-cycle ALU: it handles MULT/MULTU/DIV/DIVU over many cycles.
//  It also handles single-cycle MTHI/MTLO writes.
//  Sits beside the ALU. The CPU stalls on busy; MFHI/MFLO read hi/lo directly.
// PARAMETERS
//  WIDTH   32  operand width; HI and LO are each WIDTH bits
//  UNROLL  1   multiply bits retired per cycle; legal values 1, 2, 4 (must divide WIDTH); divide is always 1 bit/cycle
// PORTS
//  clk     in   1      clock
//  rst_n   in   1      asynchronous reset, active low
//  start   in   1      request; sampled only while busy=0
//  oper    in   3      `MDU_MULT/`MDU_MULTU/`MDU_DIV/`MDU_DIVU/`MDU_MTHI/`MDU_MTLO
//  srcA    in   WIDTH  multiplicand/dividend; write data for MTHI/MTLO
//  srcB    in   WIDTH  multiplier/divisor
//  cancel  in   1      flush; aborts the in-flight operation
//  busy    out  1      operation in progress
//  done    out  1      one-cycle pulse in the cycle hi/lo hold a new result
//  hi      out  WIDTH  HI register (high product / remainder)
//  lo      out  WIDTH  LO register (low product / quotient)
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; busy=0, done=0, hi=0, lo=0; all working registers cleared.
//  States:
//   - IDLE -> MUL on start & MULT/MULTU.
//   - IDLE -> DIV on start & DIV/DIVU.
//   - MUL -> FIX after WIDTH/UNROLL iterations; DIV -> FIX after WIDTH iterations.
//   - FIX -> IDLE: writes hi/lo and pulses done.
//  Latency, counting from edge E0 (start sampled, busy rises):
//   - MUL: hi/lo update and done=1 at edge E0+WIDTH/UNROLL+1; busy falls at the same edge.
//   - DIV: same rule with WIDTH in place of WIDTH/UNROLL. WIDTH=32, UNROLL=1 gives 33 for both.
//   - MTHI/MTLO: register written at E0; done=1 for that one cycle; busy stays 0; no state change.
//  Operand capture at E0:
//   - Signed ops latch |srcA|, |srcB| and the result signs.
//   - Later changes on srcA/srcB/oper are ignored.
//  hi/lo hold their old values during MUL/DIV; working product/remainder registers are separate.
//  MUL: shift-add of UNROLL partial products per cycle into a 2*WIDTH accumulator.
//   - FIX negates the 2*WIDTH result if sign(A)^sign(B) for MULT.
//  DIV: restoring, one quotient bit per cycle. In FIX:
//   - quotient negated if sign(A)^sign(B) (truncate toward zero);
//   - remainder takes sign of dividend.
//  Divide by zero, DIV or DIVU:
//   - lo = all ones, hi = srcA as captured (unmodified).
//   - Normal latency; no exception signalled.
//  Signed overflow, DIV of -2^(WIDTH-1) by -1: lo = 0x8000_0000, hi = 0.
//  Start while busy=1: ignored; no queueing. The CPU must hold the request until busy=0.
//  cancel=1 while busy:
//   - IDLE at the next edge; hi/lo unchanged; no done.
//   - cancel has priority over FIX completion in the same cycle.
//  cancel while idle: no effect. cancel and start together while idle: start is ignored.
//  done never asserts while rst_n=0. Mid-operation reset discards the operation entirely.
// STRUCTURE
//  sm_cpu.vh gains `MDU_* oper codes (3 bits) and an `MDU_NOP encoding.
//  One sub-module, sm_mdu_divstep: combinational restoring step.
//   - (rem, quot, divisor) -> (rem', quot'); instantiated once in sm_mdu.
//  Multiplier step inline: generate loop over UNROLL; iteration counter sized $clog2(WIDTH)+1.
// TESTING
//  1. MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; done exactly 33 edges after start.
//     Repeat with UNROLL=4 -> done after 9 edges.
//  2. MULT -3*7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
//     DIVU 7/2 -> lo=3, hi=1.
//     DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//  3. DIVU 0x1234/0 -> lo=0xFFFFFFFF, hi=0x1234.
//     DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
//  4. Start MULT, change srcA/srcB and pulse start at cycle 5 -> original result, one done only.
//     hi/lo stay at old values until the done edge.
//  5. MTLO 0xCAFE -> lo=0xCAFE next edge, done 1 cycle, busy 0.
//     Then DIVU with cancel at cycle 10 -> no done, lo stays 0xCAFE; a new start is accepted the following cycle.
//  6. rst_n low at cycle 15 of a DIV -> busy=0, hi=lo=0 immediately (async).
//     After release, MULTU 6*7 -> lo=42, hi=0.

Source files
------------

// File: rtl/sm_mdu_pkg.sv
// Shared types and operation codes for the schoolMIPS multiply/divide unit.
package sm_mdu_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_FIX  = 2'd3
   } mdu_state_t;

   localparam logic [2:0] MDU_NOP   = 3'd0;
   localparam logic [2:0] MDU_MULT  = 3'd1;
   localparam logic [2:0] MDU_MULTU = 3'd2;
   localparam logic [2:0] MDU_DIV   = 3'd3;
   localparam logic [2:0] MDU_DIVU  = 3'd4;
   localparam logic [2:0] MDU_MTHI  = 3'd5;
   localparam logic [2:0] MDU_MTLO  = 3'd6;

endpackage

// File: rtl/sm_mdu_divstep.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, subtract the divisor when it fits, and shift the quotient bit in.
module sm_mdu_divstep #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] i_rem,
   input  logic [WIDTH-1:0] i_quot,
   input  logic [WIDTH-1:0] i_div,
   output logic [WIDTH-1:0] o_rem,
   output logic [WIDTH-1:0] o_quot
);

   logic [WIDTH:0]   w_shift;
   logic [WIDTH-1:0] w_diff;
   logic             w_fits;

   assign w_shift = {i_rem, i_quot[WIDTH-1]};
   assign w_fits  = (w_shift >= {1'b0, i_div});
   // When the divisor fits, the true difference is below 2^WIDTH, so a WIDTH-bit subtract is exact.
   assign w_diff  = w_shift[WIDTH-1:0] - i_div;

   assign o_rem  = w_fits ? w_diff : w_shift[WIDTH-1:0];
   assign o_quot = {i_quot[WIDTH-2:0], w_fits};

endmodule

// File: rtl/sm_mdu.sv
// Iterative MULT/MULTU/DIV/DIVU with architectural HI/LO plus single-cycle MTHI/MTLO.
// Result lands WIDTH/UNROLL+1 (multiply) or WIDTH+1 (divide) edges after start; start is ignored while busy.
module sm_mdu
   import sm_mdu_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int UNROLL = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2:0]       oper,
   input  logic [WIDTH-1:0] srcA,
   input  logic [WIDTH-1:0] srcB,
   input  logic             cancel,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] MUL_ITERS = CW'(WIDTH / UNROLL);
   localparam logic [CW-1:0] DIV_ITERS = CW'(WIDTH);

   mdu_state_t         r_state;
   mdu_state_t         w_state_nxt;
   logic [CW-1:0]      r_cnt;
   logic [2*WIDTH-1:0] r_acc;
   logic [WIDTH-1:0]   r_opd;
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;
   logic               r_neg_q;
   logic               r_neg_r;
   logic               r_dz;
   logic               r_is_div;
   logic               r_done;

   logic               w_go;
   logic               w_signed;
   logic               w_sa;
   logic               w_sb;
   logic [WIDTH-1:0]   w_absa;
   logic [WIDTH-1:0]   w_absb;
   logic               w_is_mul_op;
   logic               w_is_div_op;

   assign w_go        = start & ~cancel & (r_state == ST_IDLE);
   assign w_signed    = (oper == MDU_MULT) | (oper == MDU_DIV);
   assign w_is_mul_op = (oper == MDU_MULT) | (oper == MDU_MULTU);
   assign w_is_div_op = (oper == MDU_DIV)  | (oper == MDU_DIVU);
   assign w_sa        = w_signed & srcA[WIDTH-1];
   assign w_sb        = w_signed & srcB[WIDTH-1];
   assign w_absa      = w_sa ? (~srcA + 1'b1) : srcA;
   assign w_absb      = w_sb ? (~srcB + 1'b1) : srcB;

   // Shift-add multiplier: r_acc = {partial product, remaining multiplier bits}.
   logic [UNROLL:0][2*WIDTH-1:0] w_mstage;
   assign w_mstage[0] = r_acc;

   genvar g;
   generate
      for (g = 0; g < UNROLL; g++) begin : g_mul
         logic [WIDTH:0] w_sum;
         assign w_sum = {1'b0, w_mstage[g][2*WIDTH-1:WIDTH]}
                      + (w_mstage[g][0] ? {1'b0, r_opd} : {(WIDTH+1){1'b0}});
         assign w_mstage[g+1] = {w_sum, w_mstage[g][WIDTH-1:1]};
      end
   endgenerate

   logic [WIDTH-1:0] w_drem;
   logic [WIDTH-1:0] w_dquot;

   sm_mdu_divstep #(.WIDTH(WIDTH)) u_divstep (
      .i_rem  (r_acc[2*WIDTH-1:WIDTH]),
      .i_quot (r_acc[WIDTH-1:0]),
      .i_div  (r_opd),
      .o_rem  (w_drem),
      .o_quot (w_dquot)
   );

   logic [2*WIDTH-1:0] w_prod_fix;
   logic [WIDTH-1:0]   w_quot_fix;
   logic [WIDTH-1:0]   w_rem_fix;

   assign w_prod_fix = r_neg_q ? (~r_acc + 1'b1) : r_acc;
   assign w_quot_fix = r_dz ? {WIDTH{1'b1}}
                     : (r_neg_q ? (~r_acc[WIDTH-1:0] + 1'b1) : r_acc[WIDTH-1:0]);
   assign w_rem_fix  = r_neg_r ? (~r_acc[2*WIDTH-1:WIDTH] + 1'b1) : r_acc[2*WIDTH-1:WIDTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      busy        = (r_state != ST_IDLE);
      case (r_state)
         ST_IDLE: begin
            if (w_go && w_is_mul_op)      w_state_nxt = ST_MUL;
            else if (w_go && w_is_div_op) w_state_nxt = ST_DIV;
         end
         ST_MUL, ST_DIV: begin
            if (cancel)                   w_state_nxt = ST_IDLE;
            else if (r_cnt == CW'(1))     w_state_nxt = ST_FIX;
         end
         ST_FIX:  w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt    <= '0;
         r_acc    <= '0;
         r_opd    <= '0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_dz     <= 1'b0;
         r_is_div <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_go) begin
                  case (oper)
                     MDU_MULT, MDU_MULTU: begin
                        r_acc    <= {{WIDTH{1'b0}}, w_absb};
                        r_opd    <= w_absa;
                        r_cnt    <= MUL_ITERS;
                        r_neg_q  <= w_sa ^ w_sb;
                        r_is_div <= 1'b0;
                     end
                     MDU_DIV, MDU_DIVU: begin
                        r_acc    <= {{WIDTH{1'b0}}, w_absa};
                        r_opd    <= w_absb;
                        r_cnt    <= DIV_ITERS;
                        r_neg_q  <= w_sa ^ w_sb;
                        r_neg_r  <= w_sa;
                        r_dz     <= (srcB == '0);
                        r_is_div <= 1'b1;
                     end
                     MDU_MTHI: begin
                        r_hi   <= srcA;
                        r_done <= 1'b1;
                     end
                     MDU_MTLO: begin
                        r_lo   <= srcA;
                        r_done <= 1'b1;
                     end
                     default: ;
                  endcase
               end
            end
            ST_MUL: begin
               r_acc <= w_mstage[UNROLL];
               r_cnt <= r_cnt - 1'b1;
            end
            ST_DIV: begin
               r_acc <= {w_drem, w_dquot};
               r_cnt <= r_cnt - 1'b1;
            end
            ST_FIX: begin
               // A flush arriving on the completion cycle still wins: HI/LO stay architectural.
               if (!cancel) begin
                  if (r_is_div) begin
                     r_lo <= w_quot_fix;
                     r_hi <= w_rem_fix;
                  end else begin
                     r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                     r_lo <= w_prod_fix[WIDTH-1:0];
                  end
                  r_done <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign done = r_done;
   assign hi   = r_hi;
   assign lo   = r_lo;

endmodule

// File: tb/tb_sm_mdu.sv
// Directed self-checking bench for sm_mdu (UNROLL=1 and UNROLL=4 instances).
module tb_sm_mdu;
   import sm_mdu_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        start4 = 1'b0;
   logic [2:0]  oper = MDU_NOP;
   logic [31:0] srcA = '0;
   logic [31:0] srcB = '0;
   logic        cancel = 1'b0;
   logic        busy, done, busy4, done4;
   logic [31:0] hi, lo, hi4, lo4;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   sm_mdu #(.WIDTH(32), .UNROLL(1)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .oper(oper), .srcA(srcA), .srcB(srcB),
      .cancel(cancel), .busy(busy), .done(done), .hi(hi), .lo(lo)
   );

   sm_mdu #(.WIDTH(32), .UNROLL(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .start(start4), .oper(oper), .srcA(srcA), .srcB(srcB),
      .cancel(cancel), .busy(busy4), .done(done4), .hi(hi4), .lo(lo4)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Issues one request on the UNROLL=1 instance; edges counts from E0 to the done edge.
   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int edges);
      oper = op; srcA = a; srcB = b; start = 1'b1;
      tick();
      start = 1'b0;
      chk("busy_after_start", busy, 1);
      edges = 0;
      while (edges < 100) begin
         tick();
         edges++;
         if (done) break;
      end
   endtask

   initial begin
      int n;
      int dones;
      int done_at;

      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_hi", hi, 0);
      chk("rst_lo", lo, 0);
      tick();
      rst_n = 1'b1;
      tick();

      // Full-scale unsigned multiply, both unroll factors
      run_op(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, n);
      chk("multu_lat", n, 33);
      chk("multu_hi", hi, 32'hFFFF_FFFE);
      chk("multu_lo", lo, 32'h0000_0001);
      chk("multu_busy_fall", busy, 0);
      tick();
      chk("multu_done_pulse", done, 0);

      start4 = 1'b1;
      tick();
      start4 = 1'b0;
      n = 0;
      while (n < 100) begin
         tick();
         n++;
         if (done4) break;
      end
      chk("multu4_lat", n, 9);
      chk("multu4_hi", hi4, 32'hFFFF_FFFE);
      chk("multu4_lo", lo4, 32'h0000_0001);

      run_op(MDU_MULT, 32'hFFFF_FFFD, 32'd7, n);
      chk("mult_hi", hi, 32'hFFFF_FFFF);
      chk("mult_lo", lo, 32'hFFFF_FFEB);

      run_op(MDU_DIVU, 32'd7, 32'd2, n);
      chk("divu_lat", n, 33);
      chk("divu_lo", lo, 32'd3);
      chk("divu_hi", hi, 32'd1);

      run_op(MDU_DIV, 32'hFFFF_FFF9, 32'd2, n);
      chk("div_lo", lo, 32'hFFFF_FFFD);
      chk("div_hi", hi, 32'hFFFF_FFFF);

      run_op(MDU_DIVU, 32'h1234, 32'd0, n);
      chk("dz_lat", n, 33);
      chk("dz_lo", lo, 32'hFFFF_FFFF);
      chk("dz_hi", hi, 32'h1234);

      run_op(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, n);
      chk("ovf_lo", lo, 32'h8000_0000);
      chk("ovf_hi", hi, 32'h0);

      // Operand/oper changes and a second start mid-operation must be ignored
      oper = MDU_MULT; srcA = 32'd5; srcB = 32'hFFFF_FFFA; start = 1'b1;
      tick();
      start = 1'b0;
      dones = 0;
      done_at = 0;
      for (int k = 1; k <= 40; k++) begin
         tick();
         if (done) begin
            dones++;
            done_at = k;
         end
         if (k == 4) begin
            oper = MDU_DIVU; srcA = 32'd99; srcB = 32'd3; start = 1'b1;
         end
         if (k == 5) start = 1'b0;
         if (k == 20) begin
            chk("hold_hi", hi, 32'h0);
            chk("hold_lo", lo, 32'h8000_0000);
         end
      end
      chk("ignore_dones", dones, 1);
      chk("ignore_done_at", done_at, 33);
      chk("ignore_hi", hi, 32'hFFFF_FFFF);
      chk("ignore_lo", lo, 32'hFFFF_FFE2);
      chk("ignore_idle", busy, 0);

      // MTLO is a single-cycle write
      oper = MDU_MTLO; srcA = 32'hCAFE; start = 1'b1;
      tick();
      start = 1'b0;
      chk("mtlo_lo", lo, 32'hCAFE);
      chk("mtlo_done", done, 1);
      chk("mtlo_busy", busy, 0);
      tick();
      chk("mtlo_done_drop", done, 0);

      // Cancel a divide at cycle 10, then restart immediately
      oper = MDU_DIVU; srcA = 32'd100; srcB = 32'd7; start = 1'b1;
      tick();
      start = 1'b0;
      dones = 0;
      for (int k = 1; k <= 9; k++) begin
         tick();
         if (done) dones++;
      end
      cancel = 1'b1;
      tick();
      cancel = 1'b0;
      if (done) dones++;
      chk("cancel_busy", busy, 0);
      chk("cancel_lo", lo, 32'hCAFE);
      for (int k = 1; k <= 30; k++) begin
         tick();
         if (done) dones++;
      end
      chk("cancel_no_done", dones, 0);
      run_op(MDU_DIVU, 32'd100, 32'd7, n);
      chk("restart_lat", n, 33);
      chk("restart_lo", lo, 32'd14);
      chk("restart_hi", hi, 32'd2);

      // Asynchronous reset in the middle of a divide
      oper = MDU_DIV; srcA = 32'd1000; srcB = 32'd3; start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 1; k <= 15; k++) tick();
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_busy", busy, 0);
      chk("arst_done", done, 0);
      chk("arst_hi", hi, 0);
      chk("arst_lo", lo, 0);
      tick();
      rst_n = 1'b1;
      tick();
      run_op(MDU_MULTU, 32'd6, 32'd7, n);
      chk("post_rst_lat", n, 33);
      chk("post_rst_lo", lo, 32'd42);
      chk("post_rst_hi", hi, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
